// File: rtl/fletcher_checker.sv
// Receive-side Fletcher checksum verifier: accumulates a frame ending in c0,c1 and reports pass/fail.
// Optional FLETCHER_CHECKER_STATS_EN adds saturating pass/fail result counters.
module fletcher_checker #(
    parameter int unsigned CHECKSUM_WIDTH = 32,
    parameter int unsigned DATA_WIDTH     = CHECKSUM_WIDTH / 2,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      last_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic                      pass_o,
    output logic [CHECKSUM_WIDTH-1:0] sum_o,
    output logic [COUNT_WIDTH-1:0]    word_count_o
`ifdef FLETCHER_CHECKER_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0]    pass_count_o,
    output logic [COUNT_WIDTH-1:0]    fail_count_o
`endif
);

    localparam logic [DATA_WIDTH:0]    MODULO    = {1'b0, {DATA_WIDTH{1'b1}}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_RESULT
    } state_t;

    state_t                    state_q;
    logic                      ready_q;
    logic [DATA_WIDTH-1:0]     lower_q, upper_q;
    logic [COUNT_WIDTH-1:0]    count_q;
    logic                      result_valid_q;
    logic                      pass_q;
    logic [CHECKSUM_WIDTH-1:0] sum_q;
    logic [COUNT_WIDTH-1:0]    word_count_q;

    logic                      accept_d, ack_d, first_d, pass_d;
    logic [DATA_WIDTH-1:0]     lower_d, upper_d;
    logic [COUNT_WIDTH-1:0]    count_d;

    // Both operands are below 2**DATA_WIDTH, so one conditional subtract reduces mod MODULO.
    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MODULO) begin
            s = s - MODULO;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

    // Next running sums and count for the word currently offered.
    always_comb begin
        accept_d = valid_i & ready_q;
        ack_d    = result_valid_q & result_ready_i;
        first_d  = (state_q == S_IDLE);
        lower_d  = mod_add(first_d ? DATA_WIDTH'(0) : lower_q, data_i);
        upper_d  = mod_add(first_d ? DATA_WIDTH'(0) : upper_q, lower_d);
        if (first_d) begin
            count_d = COUNT_WIDTH'(1);
        end else if (count_q == COUNT_MAX) begin
            count_d = count_q;
        end else begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
        pass_d = (lower_d == DATA_WIDTH'(0)) && (upper_d == DATA_WIDTH'(0)) &&
                 (count_d >= COUNT_WIDTH'(2));
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q        <= S_IDLE;
            ready_q        <= 1'b0;
            lower_q        <= '0;
            upper_q        <= '0;
            count_q        <= '0;
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
            sum_q          <= '0;
            word_count_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    ready_q <= 1'b1;
                    if (accept_d) begin
                        lower_q <= lower_d;
                        upper_q <= upper_d;
                        count_q <= count_d;
                        if (last_i) begin
                            state_q        <= S_RESULT;
                            ready_q        <= 1'b0;
                            result_valid_q <= 1'b1;
                            pass_q         <= pass_d;
                            sum_q          <= CHECKSUM_WIDTH'({upper_d, lower_d});
                            word_count_q   <= count_d;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_RESULT: begin
                    if (ack_d) begin
                        state_q        <= S_IDLE;
                        ready_q        <= 1'b1;
                        result_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FLETCHER_CHECKER_STATS_EN
    logic [COUNT_WIDTH-1:0] pass_cnt_q, fail_cnt_q;

    // One increment per acknowledged result, holding at full scale.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if (ack_d) begin
            if (pass_q && (pass_cnt_q != COUNT_MAX)) begin
                pass_cnt_q <= pass_cnt_q + COUNT_WIDTH'(1);
            end
            if (!pass_q && (fail_cnt_q != COUNT_MAX)) begin
                fail_cnt_q <= fail_cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign pass_count_o = pass_cnt_q;
    assign fail_count_o = fail_cnt_q;
`endif

    assign ready_o        = ready_q;
    assign result_valid_o = result_valid_q;
    assign pass_o         = pass_q;
    assign sum_o          = sum_q;
    assign word_count_o   = word_count_q;

endmodule

// File: tb/tb_fletcher_checker.sv
// Directed bench for fletcher_checker at DATA_WIDTH=8 (MODULO=255): vector table plus handshake/reset sequences.
module tb_fletcher_checker;

    localparam int unsigned CW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned NW = 16;
    localparam int          NV = 7;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic          last_i;
    logic          result_valid_o;
    logic          result_ready_i;
    logic          pass_o;
    logic [CW-1:0] sum_o;
    logic [NW-1:0] word_count_o;
`ifdef FLETCHER_CHECKER_STATS_EN
    logic [NW-1:0] pass_count_o;
    logic [NW-1:0] fail_count_o;
`endif

    always #5 clk = ~clk;

    fletcher_checker #(
        .CHECKSUM_WIDTH(CW),
        .DATA_WIDTH    (DW),
        .COUNT_WIDTH   (NW)
    ) dut (
        .clock_i       (clk),
        .reset_ni      (reset_ni),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_i        (data_i),
        .last_i        (last_i),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .pass_o        (pass_o),
        .sum_o         (sum_o),
        .word_count_o  (word_count_o)
`ifdef FLETCHER_CHECKER_STATS_EN
        ,
        .pass_count_o  (pass_count_o),
        .fail_count_o  (fail_count_o)
`endif
    );

    typedef struct {
        string       name;
        logic [7:0]  w [8];
        int          n;
        logic        exp_pass;
        logic [15:0] exp_sum;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [NV];
    int   n_applied    = 0;
    int   n_miscompare = 0;
    int   exp_pc       = 0;
    int   exp_fc       = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset_ni       = 1'b0;
        valid_i        = 1'b0;
        last_i         = 1'b0;
        data_i         = '0;
        result_ready_i = 1'b0;
        repeat (cycles) tick();
        reset_ni = 1'b1;
        exp_pc   = 0;
        exp_fc   = 0;
        tick();
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        int guard;
        guard   = 0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        while (!ready_o && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_applied++;
            n_miscompare++;
            $display("FAIL ready_timeout: got ready_o=0 for %0d cycles, expected 1", guard);
        end
        tick();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic send_frame(input int idx);
        for (int i = 0; i < vecs[idx].n; i++) begin
            send_word(vecs[idx].w[i], (i == vecs[idx].n - 1));
        end
    endtask

    task automatic check_result(input int idx, input string tag);
        chk({tag, ".valid"}, 32'(result_valid_o), 32'(1));
        chk({tag, ".ready"}, 32'(ready_o), 32'(0));
        chk({tag, ".pass"},  32'(pass_o), 32'(vecs[idx].exp_pass));
        chk({tag, ".sum"},   32'(sum_o), 32'(vecs[idx].exp_sum));
        chk({tag, ".count"}, 32'(word_count_o), 32'(vecs[idx].exp_cnt));
    endtask

    task automatic note_ack(input int idx);
        if (vecs[idx].exp_pass) exp_pc++;
        else exp_fc++;
    endtask

    task automatic ack(input int idx, input string tag);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        note_ack(idx);
        chk({tag, ".ack_valid"}, 32'(result_valid_o), 32'(0));
        chk({tag, ".ack_ready"}, 32'(ready_o), 32'(1));
    endtask

    task automatic check_stats(input string tag);
`ifdef FLETCHER_CHECKER_STATS_EN
        chk({tag, ".pass_count"}, 32'(pass_count_o), 32'(exp_pc));
        chk({tag, ".fail_count"}, 32'(fail_count_o), 32'(exp_fc));
`else
        n_applied = n_applied + 0;
        if (tag.len() == 0) $display("empty stats tag");
`endif
    endtask

    initial begin
        vecs[0].name = "good";
        vecs[0].w    = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h46, 8'hC8, 8'h00};
        vecs[0].n = 7; vecs[0].exp_pass = 1'b1; vecs[0].exp_sum = 16'h0000; vecs[0].exp_cnt = 16'd7;
        vecs[1].name = "corrupt";
        vecs[1].w    = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h46, 8'hC9, 8'h00};
        vecs[1].n = 7; vecs[1].exp_pass = 1'b0; vecs[1].exp_sum = 16'h0101; vecs[1].exp_cnt = 16'd7;
        vecs[2].name = "nocheck";
        vecs[2].w    = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h00, 8'h00, 8'h00};
        vecs[2].n = 5; vecs[2].exp_pass = 1'b0; vecs[2].exp_sum = 16'hC8F0; vecs[2].exp_cnt = 16'd5;
        vecs[3].name = "oneword";
        vecs[3].w    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].n = 1; vecs[3].exp_pass = 1'b0; vecs[3].exp_sum = 16'h0000; vecs[3].exp_cnt = 16'd1;
        vecs[4].name = "twozero";
        vecs[4].w    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4].n = 2; vecs[4].exp_pass = 1'b1; vecs[4].exp_sum = 16'h0000; vecs[4].exp_cnt = 16'd2;
        vecs[5].name = "allones";
        vecs[5].w    = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5].n = 2; vecs[5].exp_pass = 1'b1; vecs[5].exp_sum = 16'h0000; vecs[5].exp_cnt = 16'd2;
        vecs[6].name = "small";
        vecs[6].w    = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6].n = 2; vecs[6].exp_pass = 1'b0; vecs[6].exp_sum = 16'h0403; vecs[6].exp_cnt = 16'd2;

        // Reset values, with ready_o low while reset is applied.
        reset_ni = 1'b0; valid_i = 1'b0; last_i = 1'b0; data_i = '0; result_ready_i = 1'b0;
        tick();
        tick();
        chk("rst.ready", 32'(ready_o), 32'(0));
        chk("rst.valid", 32'(result_valid_o), 32'(0));
        chk("rst.pass",  32'(pass_o), 32'(0));
        chk("rst.sum",   32'(sum_o), 32'(0));
        chk("rst.count", 32'(word_count_o), 32'(0));
        reset_ni = 1'b1;
        tick();
        chk("idle.ready", 32'(ready_o), 32'(1));
        check_stats("rst");

        // Table: even entries ack late, odd entries present the ack as the result appears.
        for (int v = 0; v < NV; v++) begin
            if (v % 2 == 1) begin
                result_ready_i = 1'b1;
                send_frame(v);
                check_result(v, vecs[v].name);
                tick();
                result_ready_i = 1'b0;
                note_ack(v);
                chk({vecs[v].name, ".early_ack_valid"}, 32'(result_valid_o), 32'(0));
                chk({vecs[v].name, ".early_ack_ready"}, 32'(ready_o), 32'(1));
            end else begin
                send_frame(v);
                check_result(v, vecs[v].name);
                ack(v, vecs[v].name);
            end
        end
        check_stats("table");

        // Back-pressure: result held five cycles while a stray word is offered.
        send_frame(1);
        valid_i = 1'b1;
        data_i  = 8'h55;
        last_i  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_result(1, $sformatf("bp%0d", c));
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        ack(1, "bp");
        send_frame(2);
        check_result(2, "bp_next");
        ack(2, "bp_next");
        check_stats("bp");

        // Reset mid-frame discards the partial frame.
        send_word(8'h61, 1'b0);
        send_word(8'h62, 1'b0);
        send_word(8'h63, 1'b0);
        do_reset(1);
        chk("midrst.valid", 32'(result_valid_o), 32'(0));
        chk("midrst.count", 32'(word_count_o), 32'(0));
        chk("midrst.ready", 32'(ready_o), 32'(1));
        send_frame(0);
        check_result(0, "midrst_good");
        ack(0, "midrst_good");
        send_frame(1);
        check_result(1, "stats_bad");
        ack(1, "stats_bad");
        send_frame(0);
        check_result(0, "stats_good");
        ack(0, "stats_good");
        check_stats("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
